lif_array: RTL and testbench

- Parametrised array of NUM_NEURONS independent leaky integrate-and-fire neurons.
- Leak is shift-based, with a shared runtime threshold, a selectable post-spike reset mode, and a per-neuron refractory period.
- Updates advance only on a global timestep strobe (step_en).
- Sits between the synaptic current source and the spike encoder/output logic; exposes per-neuron spikes plus one muxed membrane readout for debug.

---
 rtl/lif_array.sv | 84 ++++++++
 tb/tb_lif_array.sv | 165 ++++++++++++++++
 2 files changed

// File: rtl/lif_array.sv
// Array of leaky integrate-and-fire neurons with shift-based leak, shared threshold,
// selectable post-spike reset and per-neuron refractory period, advanced by step_en.
module lif_array #(
  parameter int unsigned NUM_NEURONS = 4,
  parameter int unsigned WIDTH       = 8,
  parameter int unsigned LEAK_SHIFT  = 1,
  parameter int unsigned REFRAC      = 2,
  parameter int unsigned SEL_W       = 2
) (
  input  logic                         clk,
  input  logic                         reset_n,
  input  logic                         step_en,
  input  logic [NUM_NEURONS*WIDTH-1:0] current,
  input  logic [WIDTH-1:0]             thresh,
  input  logic                         reset_mode,
  input  logic [SEL_W-1:0]             sel,
  output logic [NUM_NEURONS-1:0]       spike,
  output logic                         spike_any,
  output logic [WIDTH-1:0]             v_out
);

  localparam int unsigned CNT_W = (REFRAC > 0) ? $clog2(REFRAC + 1) : 1;

  logic [WIDTH-1:0]       v_q   [NUM_NEURONS];
  logic [WIDTH-1:0]       v_d   [NUM_NEURONS];
  logic [CNT_W-1:0]       cnt_q [NUM_NEURONS];
  logic [CNT_W-1:0]       cnt_d [NUM_NEURONS];
  logic [WIDTH:0]         sum_c [NUM_NEURONS];
  logic [WIDTH-1:0]       sat_c [NUM_NEURONS];
  logic [NUM_NEURONS-1:0] spike_q;
  logic [NUM_NEURONS-1:0] spike_d;
  logic                   spike_any_q;

  // Per-neuron next state: refractory hold, else leak+integrate with saturation and fire.
  always_comb begin
    for (int unsigned i = 0; i < NUM_NEURONS; i++) begin
      sum_c[i]   = ({1'b0, v_q[i]} - {1'b0, (v_q[i] >> LEAK_SHIFT)})
                 + {1'b0, current[i*WIDTH +: WIDTH]};
      sat_c[i]   = sum_c[i][WIDTH] ? {WIDTH{1'b1}} : sum_c[i][WIDTH-1:0];
      v_d[i]     = v_q[i];
      cnt_d[i]   = cnt_q[i];
      spike_d[i] = 1'b0;
      if (step_en) begin
        if (cnt_q[i] != '0) begin
          cnt_d[i] = cnt_q[i] - CNT_W'(1);
        end else if (sat_c[i] >= thresh) begin
          spike_d[i] = 1'b1;
          v_d[i]     = reset_mode ? (sat_c[i] - thresh) : '0;
          cnt_d[i]   = CNT_W'(REFRAC);
        end else begin
          v_d[i] = sat_c[i];
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      for (int unsigned i = 0; i < NUM_NEURONS; i++) begin
        v_q[i]   <= '0;
        cnt_q[i] <= '0;
      end
      spike_q     <= '0;
      spike_any_q <= 1'b0;
    end else begin
      v_q         <= v_d;
      cnt_q       <= cnt_d;
      spike_q     <= spike_d;
      spike_any_q <= |spike_d;
    end
  end

  // Debug readout mux; out-of-range select reads zero.
  always_comb begin
    v_out = '0;
    for (int unsigned i = 0; i < NUM_NEURONS; i++) begin
      if (SEL_W'(i) == sel) v_out = v_q[i];
    end
  end

  assign spike     = spike_q;
  assign spike_any = spike_any_q;

endmodule

// File: tb/tb_lif_array.sv
// Directed table-driven bench for lif_array, plus a REFRAC=0 instance for every-step firing.
module tb_lif_array;

  logic        clk;
  logic        reset_n;
  logic        step_en;
  logic [31:0] current;
  logic [7:0]  thresh;
  logic        reset_mode;
  logic [1:0]  sel;
  logic [3:0]  spike;
  logic        spike_any;
  logic [7:0]  v_out;

  logic        z_reset_n;
  logic        z_step_en;
  logic [7:0]  z_current;
  logic [7:0]  z_thresh;
  logic        z_reset_mode;
  logic [0:0]  z_sel;
  logic [0:0]  z_spike;
  logic        z_spike_any;
  logic [7:0]  z_v_out;

  int n_tests = 0;
  int n_fail  = 0;

  lif_array dut (
    .clk(clk), .reset_n(reset_n), .step_en(step_en), .current(current),
    .thresh(thresh), .reset_mode(reset_mode), .sel(sel),
    .spike(spike), .spike_any(spike_any), .v_out(v_out)
  );

  lif_array #(.NUM_NEURONS(1), .WIDTH(8), .LEAK_SHIFT(1), .REFRAC(0), .SEL_W(1)) dut0 (
    .clk(clk), .reset_n(z_reset_n), .step_en(z_step_en), .current(z_current),
    .thresh(z_thresh), .reset_mode(z_reset_mode), .sel(z_sel),
    .spike(z_spike), .spike_any(z_spike_any), .v_out(z_v_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        rst_n;
    logic        step;
    logic [31:0] cur;
    logic [7:0]  th;
    logic        rm;
    logic [1:0]  sel;
    logic [3:0]  exp_spike;
    logic        exp_any;
    logic [7:0]  exp_v;
  } vec_t;

  vec_t vq[$];

  function automatic void add(input logic rst_n, input logic step, input logic [31:0] cur,
                              input logic [7:0] th, input logic rm, input logic [1:0] s,
                              input logic [3:0] es, input logic ea, input logic [7:0] ev);
    vec_t v;
    v.rst_n = rst_n; v.step = step; v.cur = cur; v.th = th; v.rm = rm; v.sel = s;
    v.exp_spike = es; v.exp_any = ea; v.exp_v = ev;
    vq.push_back(v);
  endfunction

  task automatic chk(input string name, input int idx, input logic [31:0] act,
                     input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s[%0d]: got %0d expected %0d", name, idx, act, exp);
    end
  endtask

  initial begin
    reset_n = 1'b0; step_en = 1'b0; current = '0; thresh = 8'd200; reset_mode = 1'b0; sel = '0;
    z_reset_n = 1'b0; z_step_en = 1'b0; z_current = '0; z_thresh = '0; z_reset_mode = 1'b0;
    z_sel = '0;

    // Reset state, then reset in the middle of accumulation (overrides step_en).
    add(0, 0, 32'd0,   200, 0, 0, 4'b0000, 0, 0);
    add(1, 1, 32'd100, 200, 0, 0, 4'b0000, 0, 100);
    add(1, 1, 32'd100, 200, 0, 0, 4'b0000, 0, 150);
    add(0, 1, 32'd100, 200, 0, 0, 4'b0000, 0, 0);
    add(1, 1, 32'd100, 200, 0, 0, 4'b0000, 0, 100);

    // Leak convergence towards threshold with reset-to-zero.
    add(0, 0, 32'd0,   200, 0, 0, 4'b0000, 0, 0);
    add(1, 1, 32'd100, 200, 0, 0, 4'b0000, 0, 100);
    add(1, 1, 32'd100, 200, 0, 0, 4'b0000, 0, 150);
    add(1, 1, 32'd100, 200, 0, 0, 4'b0000, 0, 175);
    add(1, 1, 32'd100, 200, 0, 0, 4'b0000, 0, 188);
    add(1, 1, 32'd100, 200, 0, 0, 4'b0000, 0, 194);
    add(1, 1, 32'd100, 200, 0, 0, 4'b0000, 0, 197);
    add(1, 1, 32'd100, 200, 0, 0, 4'b0000, 0, 199);
    add(1, 1, 32'd100, 200, 0, 0, 4'b0001, 1, 0);
    add(1, 0, 32'd100, 200, 0, 0, 4'b0000, 0, 0);

    // Subtract mode, refractory hold, saturation.
    add(0, 0, 32'd0,   200, 1, 0, 4'b0000, 0, 0);
    add(1, 1, 32'd250, 200, 1, 0, 4'b0001, 1, 50);
    add(1, 1, 32'd250, 200, 1, 0, 4'b0000, 0, 50);
    add(1, 1, 32'd250, 200, 1, 0, 4'b0000, 0, 50);
    add(1, 1, 32'd250, 200, 1, 0, 4'b0001, 1, 55);
    add(1, 1, 32'd250, 200, 1, 0, 4'b0000, 0, 55);

    // Gated steps: large currents ignored while step_en is low.
    add(0, 0, 32'd0, 200, 0, 0, 4'b0000, 0, 0);
    for (int k = 0; k < 10; k++)
      add(1, 0, 32'hFFFF_FFFF, 200, 0, 2'(k), 4'b0000, 0, 0);
    add(1, 1, 32'h0000_001E, 200, 0, 0, 4'b0000, 0, 30);
    add(1, 0, 32'hFFFF_FFFF, 200, 0, 0, 4'b0000, 0, 30);

    // Multi-neuron independence and readout sweep.
    add(0, 0, 32'd0,         200, 0, 0, 4'b0000, 0, 0);
    add(1, 1, 32'hFFC8_3200, 200, 0, 0, 4'b1100, 1, 0);
    add(1, 0, 32'hFFC8_3200, 200, 0, 1, 4'b0000, 0, 50);
    add(1, 0, 32'hFFC8_3200, 200, 0, 2, 4'b0000, 0, 0);
    add(1, 0, 32'hFFC8_3200, 200, 0, 3, 4'b0000, 0, 0);

    for (int i = 0; i < vq.size(); i++) begin
      reset_n = vq[i].rst_n; step_en = vq[i].step; current = vq[i].cur;
      thresh = vq[i].th; reset_mode = vq[i].rm; sel = vq[i].sel;
      @(posedge clk); #1;
      chk("spike",     i, 32'(spike),     32'(vq[i].exp_spike));
      chk("spike_any", i, 32'(spike_any), 32'(vq[i].exp_any));
      chk("v_out",     i, 32'(v_out),     32'(vq[i].exp_v));
    end
    step_en = 1'b0;

    // REFRAC=0, thresh=0: fires on every step, pulses only after step edges.
    @(posedge clk); #1;
    z_reset_n = 1'b1; z_current = 8'd10;
    for (int k = 0; k < 3; k++) begin
      z_step_en = 1'b1;
      @(posedge clk); #1;
      chk("z_spike_step",   k, 32'(z_spike),     32'd1);
      chk("z_any_step",     k, 32'(z_spike_any), 32'd1);
      chk("z_v_step",       k, 32'(z_v_out),     32'd0);
      z_step_en = 1'b0;
      @(posedge clk); #1;
      chk("z_spike_idle",   k, 32'(z_spike),     32'd0);
      chk("z_any_idle",     k, 32'(z_spike_any), 32'd0);
    end

    // thresh=0 with subtract mode leaves v = sum.
    z_reset_mode = 1'b1; z_step_en = 1'b1;
    @(posedge clk); #1;
    chk("z_sub_spike1", 0, 32'(z_spike), 32'd1);
    chk("z_sub_v1",     0, 32'(z_v_out), 32'd10);
    @(posedge clk); #1;
    chk("z_sub_spike2", 0, 32'(z_spike), 32'd1);
    chk("z_sub_v2",     0, 32'(z_v_out), 32'd15);
    z_step_en = 1'b0; z_sel = 1'b1;
    @(posedge clk); #1;
    chk("z_sel_oob",    0, 32'(z_v_out), 32'd0);
    z_sel = 1'b0;
    #1;
    chk("z_sel_hold",   0, 32'(z_v_out), 32'd15);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
